// File: rtl/motor_cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// motor_cmd_arbiter_if
//   Bundles the command-source handshakes and the motor command outputs of
//   motor_cmd_arbiter.
//
//   master : the command sources / PWM side (drives requests and targets)
//   slave  : the arbiter (drives grants, owner, duty/dir commands, busy)
//
//   Signals
//     estop                        emergency stop, level, highest priority
//     rc_req / rc_gnt              remote request (level) / grant
//     rc_duty_l/r, rc_dir_l/r      remote target duty and direction
//     au_req / au_gnt              autonomous request (level) / grant
//     au_duty_l/r, au_dir_l/r      autonomous target duty and direction
//     owner                        0 none, 1 autonomous, 2 remote, 3 estop
//     duty_l/r, dir_l/r            commands to PWM generator / motor drivers
//     busy                         any side not settled on its target
// -----------------------------------------------------------------------------
interface motor_cmd_arbiter_if #(
    parameter int DUTY_W = 8
);
    logic              estop;
    logic              rc_req;
    logic [DUTY_W-1:0] rc_duty_l;
    logic [DUTY_W-1:0] rc_duty_r;
    logic              rc_dir_l;
    logic              rc_dir_r;
    logic              rc_gnt;
    logic              au_req;
    logic [DUTY_W-1:0] au_duty_l;
    logic [DUTY_W-1:0] au_duty_r;
    logic              au_dir_l;
    logic              au_dir_r;
    logic              au_gnt;
    logic [1:0]        owner;
    logic [DUTY_W-1:0] duty_l;
    logic [DUTY_W-1:0] duty_r;
    logic              dir_l;
    logic              dir_r;
    logic              busy;

    modport master (
        output estop,
        output rc_req, rc_duty_l, rc_duty_r, rc_dir_l, rc_dir_r,
        output au_req, au_duty_l, au_duty_r, au_dir_l, au_dir_r,
        input  rc_gnt, au_gnt, owner, duty_l, duty_r, dir_l, dir_r, busy
    );

    modport slave (
        input  estop,
        input  rc_req, rc_duty_l, rc_duty_r, rc_dir_l, rc_dir_r,
        input  au_req, au_duty_l, au_duty_r, au_dir_l, au_dir_r,
        output rc_gnt, au_gnt, owner, duty_l, duty_r, dir_l, dir_r, busy
    );
endinterface

// File: rtl/motor_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// motor_cmd_arbiter
//   Owns the left/right motor duty and direction commands. Arbitrates between
//   estop > remote > autonomous with one registered cycle of latency, slews
//   each side's duty toward its target, and forces duty to zero followed by a
//   dead time of DEAD_CYCLES before any direction reversal.
//
//   Ports
//     clk    : system clock
//     reset  : synchronous, active-high reset
//     bus    : motor_cmd_arbiter_if.slave (requests, targets, grants, owner,
//              duty_l/r, dir_l/r, busy)
//
//   Build option
//     MOTOR_ARB_RAMP_EN defined   : duty slews by RAMP_STEP every RAMP_DIV
//                                   cycles, reversals drain through the ramp.
//     MOTOR_ARB_RAMP_EN undefined : duty follows target every cycle, a
//                                   reversal drops duty to 0 in one cycle.
//     Dead time, arbitration and estop are identical in both builds.
// -----------------------------------------------------------------------------
module motor_cmd_arbiter #(
    parameter int DUTY_W      = 8,
    parameter int RAMP_DIV    = 256,
    parameter int RAMP_STEP   = 8,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    motor_cmd_arbiter_if.slave  bus
);

    if (RAMP_DIV < 1) begin : g_bad_ramp_div
        $error("motor_cmd_arbiter: RAMP_DIV must be >= 1");
    end
    if (RAMP_STEP < 1 || RAMP_STEP >= (2 ** DUTY_W)) begin : g_bad_ramp_step
        $error("motor_cmd_arbiter: RAMP_STEP must be in [1, 2^DUTY_W)");
    end
    if (DEAD_CYCLES < 1) begin : g_bad_dead
        $error("motor_cmd_arbiter: DEAD_CYCLES must be >= 1");
    end

    localparam int              DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_AU    = 2'd1,
        OWN_RC    = 2'd2,
        OWN_ESTOP = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DEAD
    } side_st_e;

    owner_e            r_owner;
    side_st_e          r_st   [2];
    logic [DUTY_W-1:0] r_duty [2];
    logic              r_dir  [2];
    logic [DEAD_W-1:0] r_dead [2];

    logic [DUTY_W-1:0] w_tgt_duty [2];
    logic              w_tgt_dir  [2];
    logic              w_force;

    // ---------------------------------------------------------------- arbiter
    always_ff @(posedge clk) begin
        if (reset)            r_owner <= OWN_NONE;
        else if (bus.estop)   r_owner <= OWN_ESTOP;
        else if (bus.rc_req)  r_owner <= OWN_RC;
        else if (bus.au_req)  r_owner <= OWN_AU;
        else                  r_owner <= OWN_NONE;
    end

    // Raw estop forces zero on the same edge that registers owner = 3; the
    // registered owner keeps forcing for the cycle after release.
    assign w_force = bus.estop || (r_owner == OWN_ESTOP);

    // ---------------------------------------------------------------- targets
    always_comb begin
        w_tgt_duty[0] = '0;
        w_tgt_duty[1] = '0;
        w_tgt_dir[0]  = r_dir[0];
        w_tgt_dir[1]  = r_dir[1];
        unique case (r_owner)
            OWN_RC: begin
                w_tgt_duty[0] = bus.rc_duty_l;
                w_tgt_duty[1] = bus.rc_duty_r;
                w_tgt_dir[0]  = bus.rc_dir_l;
                w_tgt_dir[1]  = bus.rc_dir_r;
            end
            OWN_AU: begin
                w_tgt_duty[0] = bus.au_duty_l;
                w_tgt_duty[1] = bus.au_duty_r;
                w_tgt_dir[0]  = bus.au_dir_l;
                w_tgt_dir[1]  = bus.au_dir_r;
            end
            default: ;
        endcase
    end

`ifdef MOTOR_ARB_RAMP_EN
    localparam int                PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W + 1)'(RAMP_STEP);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [DUTY_W:0]    w_sum   [2];
    logic [DUTY_W:0]    w_diff  [2];
    logic [DUTY_W-1:0]  w_ramp  [2];
    logic [DUTY_W-1:0]  w_drain [2];

    always_ff @(posedge clk) begin
        if (reset || r_presc == PRESC_LAST) r_presc <= '0;
        else                                r_presc <= r_presc + 1'b1;
    end

    assign w_tick = (r_presc == PRESC_LAST);

    // Slew toward target in DUTY_W+1 bits, landing exactly on target.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_sum[i]  = {1'b0, r_duty[i]} + STEP_X;
            w_diff[i] = {1'b0, r_duty[i]} - {1'b0, w_tgt_duty[i]};
            w_ramp[i] = w_tgt_duty[i];
            if (r_duty[i] < w_tgt_duty[i]) begin
                if (w_sum[i] < {1'b0, w_tgt_duty[i]}) w_ramp[i] = w_sum[i][DUTY_W-1:0];
            end else if (r_duty[i] > w_tgt_duty[i]) begin
                if (w_diff[i] > STEP_X) w_ramp[i] = r_duty[i] - STEP_X[DUTY_W-1:0];
            end
            w_drain[i] = ({1'b0, r_duty[i]} > STEP_X) ? r_duty[i] - STEP_X[DUTY_W-1:0] : '0;
        end
    end
`endif

    // --------------------------------------------------------- side FSMs (L/R)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_st[i]   <= ST_RUN;
                r_duty[i] <= '0;
                r_dir[i]  <= 1'b0;
                r_dead[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_force) begin
                    r_st[i]   <= ST_RUN;
                    r_duty[i] <= '0;
                    r_dead[i] <= '0;
                end else begin
                    unique case (r_st[i])
                        ST_RUN: begin
                            if (w_tgt_dir[i] == r_dir[i]) begin
`ifdef MOTOR_ARB_RAMP_EN
                                if (w_tick) r_duty[i] <= w_ramp[i];
`else
                                r_duty[i] <= w_tgt_duty[i];
`endif
                            end else if (r_duty[i] == '0) begin
                                r_st[i]   <= ST_DEAD;
                                r_dead[i] <= DEAD_LOAD;
                            end else begin
`ifdef MOTOR_ARB_RAMP_EN
                                r_st[i]   <= ST_DRAIN;
`else
                                r_duty[i] <= '0;
                                r_st[i]   <= ST_DEAD;
                                r_dead[i] <= DEAD_LOAD;
`endif
                            end
                        end
                        ST_DRAIN: begin
`ifdef MOTOR_ARB_RAMP_EN
                            // DEAD is entered on the same edge duty reaches
                            // zero, so zero-duty time before the flip equals
                            // DEAD_CYCLES exactly.
                            if (w_tgt_dir[i] == r_dir[i]) begin
                                r_st[i] <= ST_RUN;
                            end else if (r_duty[i] == '0) begin
                                r_st[i]   <= ST_DEAD;
                                r_dead[i] <= DEAD_LOAD;
                            end else if (w_tick) begin
                                r_duty[i] <= w_drain[i];
                                if (w_drain[i] == '0) begin
                                    r_st[i]   <= ST_DEAD;
                                    r_dead[i] <= DEAD_LOAD;
                                end
                            end
`else
                            r_duty[i] <= '0;
                            r_st[i]   <= ST_RUN;
`endif
                        end
                        ST_DEAD: begin
                            r_duty[i] <= '0;
                            if (w_tgt_dir[i] == r_dir[i]) begin
                                r_st[i] <= ST_RUN;
                            end else if (r_dead[i] == '0) begin
                                r_dir[i] <= w_tgt_dir[i];
                                r_st[i]  <= ST_RUN;
                            end else begin
                                r_dead[i] <= r_dead[i] - 1'b1;
                            end
                        end
                        default: r_st[i] <= ST_RUN;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.owner  = r_owner;
    assign bus.rc_gnt = (r_owner == OWN_RC);
    assign bus.au_gnt = (r_owner == OWN_AU);
    assign bus.duty_l = r_duty[0];
    assign bus.duty_r = r_duty[1];
    assign bus.dir_l  = r_dir[0];
    assign bus.dir_r  = r_dir[1];
    assign bus.busy   = (r_st[0] != ST_RUN) || (r_st[1] != ST_RUN) ||
                        (r_duty[0] != w_tgt_duty[0]) || (r_duty[1] != w_tgt_duty[1]);

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_motor_cmd_arbiter
//   Directed bench for motor_cmd_arbiter with RAMP_DIV=4, RAMP_STEP=50,
//   DEAD_CYCLES=10. Expectations are queued with the edge number (counted from
//   the first edge after reset release) at which they must hold and are popped
//   and compared 1 time unit after that edge. Expected sequences follow the
//   build selected by MOTOR_ARB_RAMP_EN.
// -----------------------------------------------------------------------------
module tb_motor_cmd_arbiter;

    localparam int DUTY_W = 8;

    typedef enum int unsigned {
        SG_OWNER, SG_RCG, SG_AUG, SG_DL, SG_DR, SG_DIRL, SG_DIRR, SG_BUSY
    } sig_e;

    typedef struct {
        int unsigned edge_no;
        string       tag;
        sig_e        sig;
        int unsigned val;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned edge_n;
    int unsigned n_checks;
    int unsigned n_pass;
    exp_t        sb[$];

    motor_cmd_arbiter_if #(.DUTY_W(DUTY_W)) bus ();

    motor_cmd_arbiter #(
        .DUTY_W     (DUTY_W),
        .RAMP_DIV   (4),
        .RAMP_STEP  (50),
        .DEAD_CYCLES(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            SG_OWNER: return 32'(bus.owner);
            SG_RCG:   return 32'(bus.rc_gnt);
            SG_AUG:   return 32'(bus.au_gnt);
            SG_DL:    return 32'(bus.duty_l);
            SG_DR:    return 32'(bus.duty_r);
            SG_DIRL:  return 32'(bus.dir_l);
            SG_DIRR:  return 32'(bus.dir_r);
            default:  return 32'(bus.busy);
        endcase
    endfunction

    task automatic exp(input int unsigned e, input string tag, input sig_e s, input int unsigned v);
        exp_t x;
        x.edge_no = e;
        x.tag     = tag;
        x.sig     = s;
        x.val     = v;
        sb.push_back(x);
    endtask

    task automatic step();
        exp_t        x;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        edge_n++;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            x   = sb.pop_front();
            obs = observe(x.sig);
            n_checks++;
            assert (obs === 32'(x.val)) n_pass++;
            else $error("FAIL %s @E%0d: observed %0d expected %0d", x.tag, edge_n, obs, x.val);
        end
    endtask

    task automatic to_edge(input int unsigned e);
        while (edge_n < e) step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        reset    = 1'b1;
        bus.estop = 1'b0;
        bus.rc_req = 1'b0; bus.rc_duty_l = '0; bus.rc_duty_r = '0; bus.rc_dir_l = 1'b0; bus.rc_dir_r = 1'b0;
        bus.au_req = 1'b0; bus.au_duty_l = '0; bus.au_duty_r = '0; bus.au_dir_l = 1'b0; bus.au_dir_r = 1'b0;

        // reset state
        exp(3, "rst_owner", SG_OWNER, 0);
        exp(3, "rst_rc_gnt", SG_RCG, 0);
        exp(3, "rst_au_gnt", SG_AUG, 0);
        exp(3, "rst_duty_l", SG_DL, 0);
        exp(3, "rst_duty_r", SG_DR, 0);
        exp(3, "rst_dir_l", SG_DIRL, 0);
        exp(3, "rst_dir_r", SG_DIRR, 0);
        exp(3, "rst_busy", SG_BUSY, 0);
        to_edge(3);
        edge_n = 0;

        // start-up: autonomous forward 200/200 from reset dir 0
        reset = 1'b0;
        bus.au_req = 1'b1; bus.au_duty_l = 8'd200; bus.au_duty_r = 8'd200;
        bus.au_dir_l = 1'b1; bus.au_dir_r = 1'b1;
        exp(1, "s1_owner", SG_OWNER, 1);
        exp(1, "s1_au_gnt", SG_AUG, 1);
        exp(1, "s1_rc_gnt", SG_RCG, 0);
        exp(1, "s1_busy", SG_BUSY, 1);
        exp(11, "s1_dead_dir", SG_DIRL, 0);
        exp(11, "s1_dead_duty", SG_DL, 0);
        exp(12, "s1_flip_l", SG_DIRL, 1);
        exp(12, "s1_flip_r", SG_DIRR, 1);
        exp(12, "s1_flip_duty", SG_DL, 0);
`ifdef MOTOR_ARB_RAMP_EN
        exp(15, "s1_pre_tick", SG_DL, 0);
        exp(16, "s1_ramp50", SG_DL, 50);
        exp(20, "s1_ramp100", SG_DL, 100);
        exp(24, "s1_ramp150", SG_DL, 150);
        exp(24, "s1_busy_ramp", SG_BUSY, 1);
        exp(28, "s1_ramp200_l", SG_DL, 200);
        exp(28, "s1_ramp200_r", SG_DR, 200);
        exp(28, "s1_settled", SG_BUSY, 0);
        to_edge(28);

        // preemption by remote, down-slew saturating at 30
        bus.rc_req = 1'b1; bus.rc_duty_l = 8'd30; bus.rc_dir_l = 1'b1;
        bus.rc_duty_r = 8'd200; bus.rc_dir_r = 1'b1;
        exp(29, "s2_owner", SG_OWNER, 2);
        exp(29, "s2_rc_gnt", SG_RCG, 1);
        exp(29, "s2_au_gnt", SG_AUG, 0);
        exp(29, "s2_hold200", SG_DL, 200);
        exp(32, "s2_down150", SG_DL, 150);
        exp(36, "s2_down100", SG_DL, 100);
        exp(40, "s2_down50", SG_DL, 50);
        exp(44, "s2_sat30", SG_DL, 30);
        exp(44, "s2_settled", SG_BUSY, 0);
        exp(48, "s2_no_under", SG_DL, 30);
        to_edge(48);

        // reversal of left side at duty 100
        bus.rc_duty_l = 8'd100;
        exp(52, "s3_up80", SG_DL, 80);
        exp(56, "s3_up100", SG_DL, 100);
        to_edge(56);
        bus.rc_dir_l = 1'b0;
        exp(57, "s3_drain_hold", SG_DL, 100);
        exp(57, "s3_busy", SG_BUSY, 1);
        exp(60, "s3_drain50", SG_DL, 50);
        exp(63, "s3_drain50_hold", SG_DL, 50);
        exp(64, "s3_drain0", SG_DL, 0);
        exp(64, "s3_dir_kept", SG_DIRL, 1);
        exp(73, "s3_dead_last", SG_DIRL, 1);
        exp(74, "s3_flip", SG_DIRL, 0);
        exp(74, "s3_flip_duty", SG_DL, 0);
        exp(76, "s3_rev50", SG_DL, 50);
        exp(80, "s3_rev100", SG_DL, 100);
        exp(80, "s3_settled", SG_BUSY, 0);
        exp(80, "s3_right", SG_DR, 200);
        to_edge(80);

        // estop at duty 150
        bus.rc_duty_l = 8'd150;
        exp(84, "s4_up150", SG_DL, 150);
        to_edge(84);
        bus.estop = 1'b1;
        exp(85, "s4_owner3", SG_OWNER, 3);
        exp(85, "s4_zero_l", SG_DL, 0);
        exp(85, "s4_zero_r", SG_DR, 0);
        exp(85, "s4_dir_l", SG_DIRL, 0);
        exp(85, "s4_dir_r", SG_DIRR, 1);
        exp(85, "s4_rc_gnt", SG_RCG, 0);
        exp(85, "s4_busy", SG_BUSY, 0);
        exp(89, "s4_hold", SG_OWNER, 3);
        to_edge(89);
        bus.estop = 1'b0;
        exp(90, "s4_rel_owner", SG_OWNER, 2);
        exp(90, "s4_rel_gnt", SG_RCG, 1);
        exp(90, "s4_rel_duty", SG_DL, 0);
        exp(90, "s4_rel_busy", SG_BUSY, 1);
        exp(92, "s4_res50", SG_DL, 50);
        exp(92, "s4_res_dir", SG_DIRL, 0);
        exp(100, "s4_res150", SG_DL, 150);
        exp(104, "s4_res_l", SG_DL, 150);
        exp(104, "s4_res_r", SG_DR, 200);
        to_edge(104);

        // right reversal reverted during DEAD, then all requests dropped
        bus.rc_dir_r = 1'b0;
        exp(105, "s5_drain_hold", SG_DR, 200);
        exp(105, "s5_busy", SG_BUSY, 1);
        exp(108, "s5_drain150", SG_DR, 150);
        exp(120, "s5_drain0", SG_DR, 0);
        exp(121, "s5_dead", SG_DR, 0);
        to_edge(121);
        bus.rc_dir_r = 1'b1;
        exp(122, "s5_dir_kept", SG_DIRR, 1);
        exp(122, "s5_run_duty", SG_DR, 0);
        exp(122, "s5_busy2", SG_BUSY, 1);
        exp(124, "s5_resume50", SG_DR, 50);
        to_edge(124);
        bus.rc_req = 1'b0; bus.au_req = 1'b0;
        exp(125, "s5_owner0", SG_OWNER, 0);
        exp(125, "s5_rc_gnt0", SG_RCG, 0);
        exp(125, "s5_au_gnt0", SG_AUG, 0);
        exp(128, "s5_down_l", SG_DL, 100);
        exp(128, "s5_down_r", SG_DR, 0);
        exp(136, "s5_zero_l", SG_DL, 0);
        exp(136, "s5_idle", SG_BUSY, 0);
        to_edge(136);
`else
        exp(13, "s1_jump_l", SG_DL, 200);
        exp(13, "s1_jump_r", SG_DR, 200);
        exp(13, "s1_settled", SG_BUSY, 0);
        to_edge(13);

        // drop and re-request: 200 one cycle after grant
        bus.au_req = 1'b0;
        exp(14, "s6_owner0", SG_OWNER, 0);
        exp(14, "s6_au_gnt0", SG_AUG, 0);
        exp(14, "s6_hold", SG_DL, 200);
        exp(15, "s6_zero", SG_DL, 0);
        to_edge(15);
        bus.au_req = 1'b1;
        exp(16, "s6_grant", SG_OWNER, 1);
        exp(16, "s6_pre", SG_DL, 0);
        exp(16, "s6_busy", SG_BUSY, 1);
        exp(17, "s6_jump_l", SG_DL, 200);
        exp(17, "s6_jump_r", SG_DR, 200);
        exp(17, "s6_settled", SG_BUSY, 0);
        to_edge(17);

        // preemption by remote
        bus.rc_req = 1'b1; bus.rc_duty_l = 8'd30; bus.rc_dir_l = 1'b1;
        bus.rc_duty_r = 8'd200; bus.rc_dir_r = 1'b1;
        exp(18, "s2_owner", SG_OWNER, 2);
        exp(18, "s2_rc_gnt", SG_RCG, 1);
        exp(18, "s2_au_gnt", SG_AUG, 0);
        exp(18, "s2_hold200", SG_DL, 200);
        exp(19, "s2_to30", SG_DL, 30);
        to_edge(19);

        // reversal: one-cycle drop, 10 dead cycles
        bus.rc_dir_l = 1'b0; bus.rc_duty_l = 8'd100;
        exp(20, "s3_drop", SG_DL, 0);
        exp(20, "s3_dir_kept", SG_DIRL, 1);
        exp(20, "s3_busy", SG_BUSY, 1);
        exp(29, "s3_dead_last", SG_DIRL, 1);
        exp(29, "s3_dead_duty", SG_DL, 0);
        exp(30, "s3_flip", SG_DIRL, 0);
        exp(30, "s3_flip_duty", SG_DL, 0);
        exp(31, "s3_run100", SG_DL, 100);
        exp(31, "s3_settled", SG_BUSY, 0);
        to_edge(31);

        // estop
        bus.estop = 1'b1;
        exp(32, "s4_owner3", SG_OWNER, 3);
        exp(32, "s4_zero_l", SG_DL, 0);
        exp(32, "s4_zero_r", SG_DR, 0);
        exp(32, "s4_dir_l", SG_DIRL, 0);
        exp(32, "s4_dir_r", SG_DIRR, 1);
        exp(32, "s4_rc_gnt", SG_RCG, 0);
        exp(32, "s4_busy", SG_BUSY, 0);
        exp(36, "s4_hold", SG_OWNER, 3);
        to_edge(36);
        bus.estop = 1'b0;
        exp(37, "s4_rel_owner", SG_OWNER, 2);
        exp(37, "s4_rel_l", SG_DL, 0);
        exp(37, "s4_rel_r", SG_DR, 0);
        exp(38, "s4_res_l", SG_DL, 100);
        exp(38, "s4_res_r", SG_DR, 200);
        to_edge(38);

        // right reversal reverted during DEAD, then all requests dropped
        bus.rc_dir_r = 1'b0;
        exp(39, "s5_drop", SG_DR, 0);
        exp(39, "s5_dir_kept", SG_DIRR, 1);
        exp(40, "s5_dead", SG_DR, 0);
        to_edge(40);
        bus.rc_dir_r = 1'b1;
        exp(41, "s5_dir_same", SG_DIRR, 1);
        exp(41, "s5_run_duty", SG_DR, 0);
        exp(42, "s5_resume", SG_DR, 200);
        to_edge(42);
        bus.rc_req = 1'b0; bus.au_req = 1'b0;
        exp(43, "s5_owner0", SG_OWNER, 0);
        exp(43, "s5_rc_gnt0", SG_RCG, 0);
        exp(43, "s5_au_gnt0", SG_AUG, 0);
        exp(44, "s5_zero_l", SG_DL, 0);
        exp(44, "s5_zero_r", SG_DR, 0);
        exp(44, "s5_idle", SG_BUSY, 0);
        to_edge(44);
`endif

        n_checks++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL sb_drain: observed %0d pending expected 0 pending", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/motor_cmd_arbiter.md
Name: motor_cmd_arbiter

Overview:
- Owns the two motor duty/direction command channels that feed the PWM generator.
- Arbitrates between three command sources by fixed priority: emergency stop, then remote control, then autonomous FSM.
- Slews each side's duty cycle toward its target at a controlled rate.
- Forces ramp-to-zero plus a dead time before any direction reversal, protecting the H-bridge and gearbox.

Parameters:
- DUTY_W, 8: duty-cycle width in bits.
- RAMP_DIV, 256: clock cycles per ramp tick; must be >= 1.
- RAMP_STEP, 8: duty change per ramp tick; must be >= 1 and < 2^DUTY_W.
- DEAD_CYCLES, 1000: cycles at zero duty before a direction flip; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- estop  in  1  emergency stop, level-sensitive, highest priority
- rc_req  in  1  remote source requests motor ownership (level)
- rc_duty_l, rc_duty_r  in  DUTY_W  remote target duty, left/right
- rc_dir_l, rc_dir_r  in  1  remote target direction (1 = forward)
- rc_gnt  out  1  remote source currently owns the motors
- au_req  in  1  autonomous source requests ownership (level)
- au_duty_l, au_duty_r  in  DUTY_W  autonomous target duty
- au_dir_l, au_dir_r  in  1  autonomous target direction
- au_gnt  out  1  autonomous source currently owns the motors
- owner  out  2  0 = none, 1 = autonomous, 2 = remote, 3 = estop
- duty_l, duty_r  out  DUTY_W  duty commands to the PWM generator
- dir_l, dir_r  out  1  direction commands to the motor drivers
- busy  out  1  any side not settled

Behaviour:
- Reset: duty_l = duty_r = 0, dir_l = dir_r = 0, rc_gnt = au_gnt = 0, owner = 0, busy = 0, prescaler = 0, both side FSMs in RUN, dead counters = 0.
- Arbitration is registered, one cycle of latency:
  - owner <= 3 if estop; else 2 if rc_req; else 1 if au_req; else 0.
  - rc_gnt = (owner == 2); au_gnt = (owner == 1).
  - Ownership is preemptive: a higher-priority request takes over on the next edge. There is no hold or lock.
- Targets are combinational from the registered owner: the owner's duty/dir inputs.
  - owner 0: target duty 0, target dir = current dir.
  - owner 3: handled by the estop rule below.
- Ramp tick: free-running prescaler counts 0..RAMP_DIV-1 and wraps; tick asserts when it equals RAMP_DIV-1. It is shared by both sides and runs regardless of state.
- Per-side FSM, identical and independent for left and right:
  - RUN, target dir == dir: on tick, duty moves toward target by RAMP_STEP and saturates exactly at target (never overshoots). Compute in DUTY_W+1 bits.
  - RUN, target dir != dir: go to DRAIN if duty != 0; if duty == 0, go directly to DEAD and load the dead counter with DEAD_CYCLES-1.
  - DRAIN: on tick, duty decreases by RAMP_STEP, floored at 0. When duty == 0, go to DEAD and load the counter. If target dir returns to the current dir, go back to RUN.
  - DEAD: duty held at 0; counter decrements every cycle. At counter 0: dir <= target dir, go to RUN. If target dir returns to the current dir, go to RUN immediately.
  - Total zero-duty time before a flip is exactly DEAD_CYCLES cycles.
- Estop, while owner == 3:
  - Both duties are forced to 0 at the next edge, bypassing the ramp.
  - Both FSMs are forced to RUN; dir is held.
  - After release, the next target is processed normally, so a reversal still pays the full dead time.
- busy = (either FSM != RUN) or (duty_l != target_l) or (duty_r != target_r).
- Side effect of reset dir = 0: the first forward command after reset incurs DEAD_CYCLES.
- Mid-operation reset: all state is cleared in the same cycle per the reset values above.

Optional Feature:
- Macro MOTOR_ARB_RAMP_EN.
- Defined: ramping exactly as described above.
- Undefined:
  - In RUN, duty <= target on every cycle with no tick dependency.
  - DRAIN is skipped: a direction change drops duty to 0 in one cycle, then enters DEAD.
  - Dead time, arbitration and estop behaviour are unchanged.
  - The prescaler may be removed.

Test Plan:
- Bench parameters: RAMP_DIV=4, RAMP_STEP=50, DEAD_CYCLES=10, ramp enabled.
- Scenario 1 (reset start-up): release reset; au_req=1, au_duty=200/200, au_dir=1/1 -> au_gnt=1 one cycle later; 10 dead cycles at duty 0; dir flips to 1; duty steps 50, 100, 150, 200 on successive ticks; busy falls once duty reaches 200.
- Scenario 2 (preemption and saturation): while autonomous runs at 200, assert rc_req with rc_duty_l=30, dir=1 -> rc_gnt=1, au_gnt=0 next cycle; duty_l steps 150, 100, 50, then 30 (saturates, no undershoot).
- Scenario 3 (reversal): remote at duty 100 forward, then rc_dir_l=0 -> DRAIN (duty 50, then 0), exactly 10 cycles at 0, then dir_l=0 and duty ramps up.
- Scenario 4 (estop): estop asserted at duty 150 -> duty 0 and owner=3 at the next edge; hold 5 cycles, release with rc_req still high -> owner=2, ramp resumes from 0 with no dead time since dir is unchanged.
- Scenario 5 (revert during DEAD): during DEAD, target dir reverts -> RUN the next cycle with dir unchanged; all requests dropped -> owner=0, duty ramps to 0, both gnts 0.
- Scenario 6 (ramp disabled): rebuild without MOTOR_ARB_RAMP_EN -> a 0-to-200 command with no dir change reaches 200 one cycle after grant.
